// File: rtl/mem_access_unit.sv
// Load/store unit between the pipeline and a data memory with a busy handshake.
// It formats store lanes and byte enables, stalls the pipeline during an access and formats loads.
module mem_access_unit (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [2:0]  MEM_READ,
  input  logic [2:0]  MEM_WRITE,
  input  logic [31:0] ALU_RESULT,
  input  logic [31:0] OUT2,
  input  logic [31:0] DMEM_RDATA,
  input  logic        DMEM_BUSY,
  output logic        DMEM_READ,
  output logic        DMEM_WRITE,
  output logic [31:0] DMEM_ADDR,
  output logic [31:0] DMEM_WDATA,
  output logic [3:0]  DMEM_BE,
  output logic        BUSY_WAIT,
  output logic [31:0] LOAD_DATA,
  output logic        MISALIGNED
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam logic [2:0] OP_LB  = 3'd1;
  localparam logic [2:0] OP_LH  = 3'd2;
  localparam logic [2:0] OP_LW  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_LHU = 3'd5;
  localparam logic [2:0] OP_SB  = 3'd1;
  localparam logic [2:0] OP_SH  = 3'd2;
  localparam logic [2:0] OP_SW  = 3'd3;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  logic [1:0]  state;
  logic        rd_valid;
  logic        rd_signed;
  logic [1:0]  rd_size;
  logic        wr_valid;
  logic [1:0]  wr_size;
  logic        req;
  logic [1:0]  req_size;
  logic        start;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;

  // Load attributes latched at the start of an access, used when the data returns.
  logic        ld_active;
  logic        ld_signed;
  logic [1:0]  ld_size;
  logic [1:0]  ld_offset;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_fmt;

  // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    rd_valid  = 1'b0;
    rd_signed = 1'b0;
    rd_size   = SZ_BYTE;
    case (MEM_READ)
      OP_LB:  begin rd_valid = 1'b1; rd_signed = 1'b1; rd_size = SZ_BYTE; end
      OP_LH:  begin rd_valid = 1'b1; rd_signed = 1'b1; rd_size = SZ_HALF; end
      OP_LW:  begin rd_valid = 1'b1; rd_size = SZ_WORD; end
      OP_LBU: begin rd_valid = 1'b1; rd_size = SZ_BYTE; end
      OP_LHU: begin rd_valid = 1'b1; rd_size = SZ_HALF; end
      default: ;
    endcase

    wr_valid = 1'b0;
    wr_size  = SZ_BYTE;
    case (MEM_WRITE)
      OP_SB: begin wr_valid = 1'b1; wr_size = SZ_BYTE; end
      OP_SH: begin wr_valid = 1'b1; wr_size = SZ_HALF; end
      OP_SW: begin wr_valid = 1'b1; wr_size = SZ_WORD; end
      default: ;
    endcase
  end

  // A valid load always wins over a simultaneous store.
  assign req      = rd_valid | wr_valid;
  assign req_size = rd_valid ? rd_size : wr_size;

  always_comb begin
    MISALIGNED = 1'b0;
    if (req) begin
      if (req_size == SZ_HALF && ALU_RESULT[0])
        MISALIGNED = 1'b1;
      else if (req_size == SZ_WORD && ALU_RESULT[1:0] != 2'b00)
        MISALIGNED = 1'b1;
    end
  end

  assign start     = (state == IDLE) && req && !MISALIGNED;
  assign BUSY_WAIT = !RESET && (start || state == ACCESS);

  always_comb begin
    be_next = 4'b1111;
    case (req_size)
      SZ_BYTE: be_next = 4'b0001 << ALU_RESULT[1:0];
      SZ_HALF: be_next = ALU_RESULT[1] ? 4'b1100 : 4'b0011;
      default: be_next = 4'b1111;
    endcase
  end

  always_comb begin
    wdata_next = 32'h0;
    if (!rd_valid) begin
      case (wr_size)
        SZ_BYTE: wdata_next = {4{OUT2[7:0]}};
        SZ_HALF: wdata_next = {2{OUT2[15:0]}};
        default: wdata_next = OUT2;
      endcase
    end
  end

  always_comb begin
    lane_byte = DMEM_RDATA[7:0];
    case (ld_offset)
      2'd1:    lane_byte = DMEM_RDATA[15:8];
      2'd2:    lane_byte = DMEM_RDATA[23:16];
      2'd3:    lane_byte = DMEM_RDATA[31:24];
      default: lane_byte = DMEM_RDATA[7:0];
    endcase
    lane_half = ld_offset[1] ? DMEM_RDATA[31:16] : DMEM_RDATA[15:0];

    load_fmt = DMEM_RDATA;
    case (ld_size)
      SZ_BYTE: load_fmt = {{24{ld_signed & lane_byte[7]}}, lane_byte};
      SZ_HALF: load_fmt = {{16{ld_signed & lane_half[15]}}, lane_half};
      default: load_fmt = DMEM_RDATA;
    endcase
  end

  // NOTE: sequential state is written with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      // NOTE: the datapath registers are cleared along with control so outputs are defined straight out of reset.
      state      <= IDLE;
      DMEM_READ  <= 1'b0;
      DMEM_WRITE <= 1'b0;
      DMEM_ADDR  <= 32'h0;
      DMEM_WDATA <= 32'h0;
      DMEM_BE    <= 4'h0;
      LOAD_DATA  <= 32'h0;
      ld_active  <= 1'b0;
      ld_signed  <= 1'b0;
      ld_size    <= SZ_BYTE;
      ld_offset  <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            DMEM_ADDR  <= {ALU_RESULT[31:2], 2'b00};
            DMEM_BE    <= be_next;
            DMEM_WDATA <= wdata_next;
            DMEM_READ  <= rd_valid;
            DMEM_WRITE <= !rd_valid;
            ld_active  <= rd_valid;
            ld_signed  <= rd_signed;
            ld_size    <= rd_size;
            ld_offset  <= ALU_RESULT[1:0];
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          if (!DMEM_BUSY) begin
            DMEM_READ  <= 1'b0;
            DMEM_WRITE <= 1'b0;
            if (ld_active)
              LOAD_DATA <= load_fmt;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
